// File: rtl/sccomp_runctl.sv
// Load/run/dump controller for the sccomp single-cycle RISC-V system.
// Define SCCOMP_RUNCTL_DUMP_EN to include the register dump stream after each run.
module sccomp_runctl #(
    parameter int          IM_DEPTH   = 256,
    parameter logic [31:0] HALT_PC    = 32'hF000_0100,
    parameter int          MAX_CYCLES = 1000,
    localparam int         AW         = $clog2(IM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          cpu_rstn,
    output logic          cpu_clk_en,
    input  logic [31:0]   cpu_pc,
    output logic [4:0]    reg_sel,
    input  logic [31:0]   reg_data,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [31:0]   dump_data,
    output logic [4:0]    dump_idx,
    output logic          dump_last,
    output logic          busy,
    output logic          done,
    output logic [1:0]    halt_cause,
    output logic [31:0]   cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

`ifdef SCCOMP_RUNCTL_DUMP_EN
    localparam state_t S_HALT_NEXT = S_DUMP;
`else
    localparam state_t S_HALT_NEXT = S_DONE;
`endif

    state_t        r_state;
    logic [AW-1:0] r_widx;
    logic [31:0]   r_cycle;
    logic [1:0]    r_cause;
    logic          r_cpu_rstn;
`ifdef SCCOMP_RUNCTL_DUMP_EN
    logic [4:0]    r_ridx;
`endif

    logic          w_ld_hs;
    logic          w_pc_hit;
    logic [31:0]   w_cycle_inc;

    assign w_ld_hs     = (r_state == S_LOAD) && ld_valid;
    assign w_pc_hit    = (cpu_pc == HALT_PC);
    assign w_cycle_inc = r_cycle + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_widx     <= '0;
            r_cycle    <= '0;
            r_cause    <= '0;
            r_cpu_rstn <= 1'b0;
`ifdef SCCOMP_RUNCTL_DUMP_EN
            r_ridx     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // A (re)load always starts with the CPU held in reset.
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_widx     <= '0;
                        r_cycle    <= '0;
                        r_cause    <= '0;
                        r_cpu_rstn <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_ld_hs) begin
                        r_widx <= r_widx + AW'(1);
                        if (ld_last) begin
                            r_state    <= S_RUN;
                            r_cpu_rstn <= 1'b1;
                        end else if (r_widx == AW'(IM_DEPTH - 1)) begin
                            r_state <= S_DONE;
                            r_cause <= 2'd3;
                        end
                    end
                end
                S_RUN: begin
                    // PC match takes priority and suppresses the count for that cycle.
                    if (w_pc_hit) begin
                        r_state <= S_HALT_NEXT;
                        r_cause <= 2'd1;
`ifdef SCCOMP_RUNCTL_DUMP_EN
                        r_ridx  <= '0;
`endif
                    end else begin
                        r_cycle <= w_cycle_inc;
                        if (w_cycle_inc == 32'(MAX_CYCLES)) begin
                            r_state <= S_HALT_NEXT;
                            r_cause <= 2'd2;
`ifdef SCCOMP_RUNCTL_DUMP_EN
                            r_ridx  <= '0;
`endif
                        end
                    end
                end
`ifdef SCCOMP_RUNCTL_DUMP_EN
                S_DUMP: begin
                    if (dump_ready) begin
                        r_ridx <= r_ridx + 5'd1;
                        if (r_ridx == 5'd31) begin
                            r_state <= S_DONE;
                        end
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ld_ready    = (r_state == S_LOAD);
    assign im_we       = w_ld_hs;
    assign im_addr     = w_ld_hs ? r_widx : '0;
    assign im_wdata    = w_ld_hs ? ld_data : '0;
    assign cpu_rstn    = r_cpu_rstn;
    assign cpu_clk_en  = (r_state == S_RUN) && !w_pc_hit;
    assign busy        = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_DUMP);
    assign done        = (r_state == S_DONE);
    assign halt_cause  = r_cause;
    assign cycle_count = r_cycle;

`ifdef SCCOMP_RUNCTL_DUMP_EN
    // The CPU is frozen during the dump, so reg_data can pass straight through.
    assign dump_valid = (r_state == S_DUMP);
    assign reg_sel    = dump_valid ? r_ridx : '0;
    assign dump_idx   = dump_valid ? r_ridx : '0;
    assign dump_data  = dump_valid ? reg_data : '0;
    assign dump_last  = dump_valid && (r_ridx == 5'd31);
`else
    logic w_unused;
    assign w_unused   = ^{dump_ready, reg_data};
    assign dump_valid = 1'b0;
    assign reg_sel    = '0;
    assign dump_idx   = '0;
    assign dump_data  = '0;
    assign dump_last  = 1'b0;
`endif

endmodule

// File: tb/tb_sccomp_runctl.sv
// Self-checking bench for sccomp_runctl: randomized load/run/dump sequences against a rule-level model.
module tb_sccomp_runctl;
    localparam int          IM_DEPTH   = 4;
    localparam int          AW         = 2;
    localparam logic [31:0] HALT_PC    = 32'hF000_0100;
    localparam int          MAX_CYCLES = 20;

    logic          clk = 1'b0;
    logic          rst, start, ld_valid, ld_last, dump_ready;
    logic [31:0]   ld_data, cpu_pc, reg_data, reg_base;
    logic          ld_ready, im_we, cpu_rstn, cpu_clk_en;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata, dump_data, cycle_count;
    logic [4:0]    reg_sel, dump_idx;
    logic          dump_valid, dump_last, busy, done;
    logic [1:0]    halt_cause;

    logic [31:0]   prog [IM_DEPTH];
    int            n_tests = 0;
    int            n_fail  = 0;

    sccomp_runctl #(.IM_DEPTH(IM_DEPTH), .HALT_PC(HALT_PC), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_rstn(cpu_rstn), .cpu_clk_en(cpu_clk_en), .cpu_pc(cpu_pc),
        .reg_sel(reg_sel), .reg_data(reg_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_idx(dump_idx), .dump_last(dump_last),
        .busy(busy), .done(done), .halt_cause(halt_cause), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Register-file stub: a frozen CPU returning base + register number.
    assign reg_data = reg_base + {27'd0, reg_sel};

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        if ($urandom_range(0, 1) == 0) p = $urandom;
        else p = HALT_PC ^ (32'd1 << $urandom_range(0, 31));
        if (p == HALT_PC) p = p ^ 32'd4;
        return p;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1; ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic fill_prog();
        for (int i = 0; i < IM_DEPTH; i++) prog[i] = $urandom;
    endtask

    task automatic load_words(input int n, input bit last_on_end, input int gap_pct);
        int acc = 0;
        int guard = 0;
        while (acc < n && guard < 200) begin
            @(negedge clk);
            start    = 1'b0;
            ld_valid = ($urandom_range(0, 99) >= gap_pct);
            ld_data  = prog[acc];
            ld_last  = last_on_end && (acc == n - 1);
            #1;
            n_tests++;
            if (ld_ready !== 1'b1 || cpu_rstn !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL load_state: ld_ready=%b cpu_rstn=%b busy=%b, expected 1/0/1", ld_ready, cpu_rstn, busy);
            end
            n_tests++;
            if (cycle_count !== 32'd0 || halt_cause !== 2'd0) begin
                n_fail++;
                $display("FAIL load_status_clear: cycle_count=%0d halt_cause=%0d, expected 0/0", cycle_count, halt_cause);
            end
            n_tests++;
            if (ld_valid) begin
                if (im_we !== 1'b1 || im_addr !== AW'(acc) || im_wdata !== prog[acc]) begin
                    n_fail++;
                    $display("FAIL load_write: we=%b addr=%0d data=%h, expected 1/%0d/%h", im_we, im_addr, im_wdata, acc, prog[acc]);
                end
                acc++;
            end else if (im_we !== 1'b0) begin
                n_fail++;
                $display("FAIL load_idle_we: im_we=%b, expected 0", im_we);
            end
            guard++;
        end
        if (acc < n) begin
            n_tests++; n_fail++;
            $display("FAIL load_timeout: accepted %0d words, expected %0d", acc, n);
        end
    endtask

    // Drive the run phase; the halt cycle (1-based, 0 = never) sets the expected length.
    task automatic run_phase(input int hcyc, output int exp_cnt, output logic [1:0] exp_cause);
        bit hit;
        int len;
        hit       = (hcyc != 0) && (hcyc <= MAX_CYCLES);
        len       = hit ? hcyc : MAX_CYCLES;
        exp_cnt   = hit ? hcyc - 1 : MAX_CYCLES;
        exp_cause = hit ? 2'd1 : 2'd2;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
            cpu_pc = (k == hcyc) ? HALT_PC : rand_pc();
            #1;
            n_tests++;
            if (cpu_clk_en !== (k != hcyc) || cpu_rstn !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL run_cycle%0d: clk_en=%b rstn=%b busy=%b, expected %b/1/1", k, cpu_clk_en, cpu_rstn, busy, (k != hcyc));
            end
        end
    endtask

    task automatic finish_phase(input int ready_mode, input int exp_cnt, input logic [1:0] exp_cause);
        @(negedge clk);
        start = 1'b0; dump_ready = 1'b0; cpu_pc = rand_pc();
        #1;
        n_tests++;
        if (cycle_count !== 32'(exp_cnt) || halt_cause !== exp_cause) begin
            n_fail++;
            $display("FAIL halt_status: cycle_count=%0d cause=%0d, expected %0d/%0d", cycle_count, halt_cause, exp_cnt, exp_cause);
        end
        n_tests++;
        if (cpu_clk_en !== 1'b0 || cpu_rstn !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_cpu: clk_en=%b rstn=%b, expected 0/1", cpu_clk_en, cpu_rstn);
        end
`ifdef SCCOMP_RUNCTL_DUMP_EN
        begin
            int exp_idx = 0;
            int guard = 0;
            while (exp_idx < 32 && guard < 400) begin
                if (guard != 0) @(negedge clk);
                dump_ready = (ready_mode == 0) ? guard[0] : 1'($urandom_range(0, 1));
                #1;
                n_tests++;
                if (dump_valid !== 1'b1 || dump_idx !== exp_idx[4:0] || reg_sel !== exp_idx[4:0] ||
                    dump_data !== reg_base + 32'(exp_idx) || dump_last !== (exp_idx == 31) ||
                    cpu_clk_en !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL dump_beat: valid=%b idx=%0d sel=%0d data=%h last=%b en=%b done=%b, expected 1/%0d/%0d/%h/%b/0/0",
                             dump_valid, dump_idx, reg_sel, dump_data, dump_last, cpu_clk_en, done,
                             exp_idx, exp_idx, reg_base + 32'(exp_idx), (exp_idx == 31));
                end
                if (dump_ready) exp_idx++;
                guard++;
            end
            if (exp_idx < 32) begin
                n_tests++; n_fail++;
                $display("FAIL dump_timeout: %0d beats, expected 32", exp_idx);
            end
            @(negedge clk);
            dump_ready = 1'b0;
            #1;
            n_tests++;
            if (done !== 1'b1 || busy !== 1'b0 || dump_valid !== 1'b0 || cpu_rstn !== 1'b1 || halt_cause !== exp_cause) begin
                n_fail++;
                $display("FAIL dump_done: done=%b busy=%b valid=%b rstn=%b cause=%0d, expected 1/0/0/1/%0d",
                         done, busy, dump_valid, cpu_rstn, halt_cause, exp_cause);
            end
        end
`else
        n_tests++;
        if (ready_mode < 0 || done !== 1'b1 || busy !== 1'b0 || dump_valid !== 1'b0 || reg_sel !== 5'd0 || dump_data !== 32'd0) begin
            n_fail++;
            $display("FAIL run_done: done=%b busy=%b valid=%b sel=%0d data=%h, expected 1/0/0/0/0",
                     done, busy, dump_valid, reg_sel, dump_data);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ld_valid = 1'b1; ld_last = 1'b0; ld_data = 32'hDEAD_BEEF;
        dump_ready = 1'b1; cpu_pc = HALT_PC; reg_base = 32'h1000;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || cpu_rstn !== 1'b0 || cpu_clk_en !== 1'b0 || ld_ready !== 1'b0 || im_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b rstn=%b en=%b ready=%b we=%b, expected all 0",
                     busy, done, cpu_rstn, cpu_clk_en, ld_ready, im_we);
        end
        n_tests++;
        if (halt_cause !== 2'd0 || cycle_count !== 32'd0 || dump_valid !== 1'b0 || dump_last !== 1'b0 ||
            reg_sel !== 5'd0 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_status: cause=%0d count=%0d valid=%b last=%b sel=%0d idx=%0d data=%h, expected all 0",
                     halt_cause, cycle_count, dump_valid, dump_last, reg_sel, dump_idx, dump_data);
        end
        @(negedge clk);
        rst = 1'b0; ld_valid = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: busy=%b ld_ready=%b, expected 0/0", busy, ld_ready);
        end
    endtask

    task automatic test_load();
        prog[0] = 32'h0050_0093; prog[1] = 32'h0060_0113; prog[2] = 32'h0020_81B3;
        pulse_start();
        load_words(3, 1'b1, 0);
    endtask

    task automatic test_pc_halt();
        int c; logic [1:0] k;
        reg_base = 32'h1000;
        run_phase(11, c, k);
        finish_phase(0, c, k);
    endtask

    task automatic test_timeout();
        int c; logic [1:0] k;
        fill_prog();
        reg_base = $urandom;
        pulse_start();
        load_words($urandom_range(1, IM_DEPTH), 1'b1, 40);
        run_phase(0, c, k);
        finish_phase(1, c, k);
    endtask

    task automatic test_back_to_back();
        int c; logic [1:0] k;
        for (int it = 0; it < 6; it++) begin
            fill_prog();
            reg_base = $urandom;
            pulse_start();
            load_words($urandom_range(1, IM_DEPTH), 1'b1, 30);
            run_phase($urandom_range(0, MAX_CYCLES + 5), c, k);
            finish_phase(1, c, k);
        end
    endtask

    task automatic test_overflow();
        fill_prog();
        pulse_start();
        load_words(IM_DEPTH, 1'b0, 30);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_last = 1'b0;
            #1;
            n_tests++;
            if (done !== 1'b1 || halt_cause !== 2'd3 || cpu_rstn !== 1'b0 || busy !== 1'b0 || im_we !== 1'b0 || cpu_clk_en !== 1'b0) begin
                n_fail++;
                $display("FAIL overflow: done=%b cause=%0d rstn=%b busy=%b we=%b en=%b, expected 1/3/0/0/0/0",
                         done, halt_cause, cpu_rstn, busy, im_we, cpu_clk_en);
            end
        end
    endtask

    task automatic test_reset_busy();
        fill_prog();
        pulse_start();
        load_words(2, 1'b0, 0);
        @(negedge clk);
        start = 1'b1; ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        @(negedge clk);
        start = 1'b0; ld_valid = 1'b1; ld_last = 1'b1; ld_data = prog[2];
        #1;
        n_tests++;
        if (im_we !== 1'b1 || im_addr !== 2'd2 || im_wdata !== prog[2]) begin
            n_fail++;
            $display("FAIL start_ignored_load: we=%b addr=%0d data=%h, expected 1/2/%h", im_we, im_addr, im_wdata, prog[2]);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            ld_valid = 1'b0; ld_last = 1'b0; start = (k == 3); cpu_pc = rand_pc();
            #1;
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_tests++;
        if (cycle_count !== 32'd5 || busy !== 1'b1 || cpu_rstn !== 1'b1) begin
            n_fail++;
            $display("FAIL run_before_rst: count=%0d busy=%b rstn=%b, expected 5/1/1", cycle_count, busy, cpu_rstn);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || cpu_rstn !== 1'b0 || cpu_clk_en !== 1'b0 ||
            cycle_count !== 32'd0 || halt_cause !== 2'd0 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_run: busy=%b done=%b rstn=%b en=%b count=%0d cause=%0d ready=%b, expected 0/0/0/0/0/0/0",
                     busy, done, cpu_rstn, cpu_clk_en, cycle_count, halt_cause, ld_ready);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_pc_halt();
        test_timeout();
        test_back_to_back();
        test_overflow();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
